// File: rtl/serial_adder_pkg.sv
// Shared constants and types for the bit-serial adder: FSM encoding,
// default operand width and counter sizing.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Bit counter width; the exit compare at w-1 means wrap-around never happens.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Gate-level one-bit full adder used as the single arithmetic bit-slice
// of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  wire ab_x_s;
  wire ab_a_s;
  wire cx_a_s;

  xor g_x1 (ab_x_s, a, b);
  xor g_x2 (sum, ab_x_s, cin);
  and g_a1 (ab_a_s, a, b);
  and g_a2 (cx_a_s, ab_x_s, cin);
  or  g_o1 (cout, ab_a_s, cx_a_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through one full adder,
// one bit per clock, with the sum assembled MSB-insert into a shift register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            busy_r;
  logic            done_r;
  logic            load_s;
  logic            shift_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             fa_sum_s;
  logic             fa_cout_s;

  fulladder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Control state register: FSM state, bit counter and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Next-state logic; start is honoured only when not busy (IDLE or DONE).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control outputs: datapath load/shift strobes and next counter value.
  always_comb begin
    load_s    = 1'b0;
    shift_s   = 1'b0;
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_s    = 1'b1;
          cnt_nxt_s = {CW{1'b0}};
        end else begin
          load_s    = 1'b0;
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SHIFT: begin
        shift_s   = 1'b1;
        cnt_nxt_s = cnt_r + CW'(1);
      end
      default: begin
        load_s    = 1'b0;
        shift_s   = 1'b0;
        cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // Datapath: operand shift registers, carry flop and sum shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      carry_r <= cin;
    end else if (shift_s) begin
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
      carry_r <= fa_cout_s;
    end else begin
      a_sh_r  <= a_sh_r;
      b_sh_r  <= b_sh_r;
      sum_r   <= sum_r;
      carry_r <= carry_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: table-driven WIDTH=8 vectors, multi-cycle
// corner sequences, and an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int errors;
  int checks;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run one WIDTH=8 operation from a non-busy state and check result, latency, hold.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec);
    int cyc;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy8), 32'd1);
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency8", 32'(cyc), 32'd9);
    chk("busy_at_done", 32'(busy8), 32'd0);
    chk("sum8", 32'(sum8), 32'(es));
    chk("cout8", 32'(cout8), 32'(ec));
    @(negedge clk);
    chk("done_one_cycle", 32'(done8), 32'd0);
    @(negedge clk);
    chk("sum_hold", 32'(sum8), 32'(es));
    chk("cout_hold", 32'(cout8), 32'(ec));
  endtask

  // Run one WIDTH=4 operation and compare {cout,sum} with the bench's own sum.
  task automatic op4(input int ia, input int ib, input int ic);
    int cyc;
    logic [4:0] exp;
    exp = 5'(ia + ib + ic);
    @(negedge clk);
    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency4", 32'(cyc), 32'd5);
    chk("sweep4", 32'({cout4, sum4}), 32'(exp));
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [7:0] dsum;
    logic       dcout;

    errors = 0; checks = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);

    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
    end

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0; dsum = 8'h00; dcout = 1'b0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (i == 3) begin
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      end
      if (done8) begin
        ndone++;
        dsum = sum8; dcout = cout8; cyc = i;
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_done_cycle", 32'(cyc), 32'd9);
    chk("ignore_sum", 32'(dsum), 32'hFF);
    chk("ignore_cout", 32'(dcout), 32'd0);

    // Reset four cycles into an operation.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_sum", 32'(sum8), 32'd0);
    chk("mid_rst_cout", 32'(cout8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    chk("mid_rst_sum_after", 32'(sum8), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_latency", 32'(cyc), 32'd9);
    chk("b2b_first_sum", 32'(sum8), 32'h10);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_done_low", 32'(done8), 32'd0);
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_latency", 32'(cyc), 32'd9);
    chk("b2b_sum", 32'(sum8), 32'h00);
    chk("b2b_cout", 32'(cout8), 32'd1);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op4(ia, ib, ic);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to add a, b, cin; sampled only when busy=0.
REQ-005 SHALL have port a, input, WIDTH: operand A, captured on the accepted start.
REQ-006 SHALL have port b, input, WIDTH: operand B, captured on the accepted start.
REQ-007 SHALL have port cin, input, 1: carry-in, captured on the accepted start.
REQ-008 SHALL have port busy, output, 1: high while an addition is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when sum and cout are valid.
REQ-010 SHALL have port sum, output, WIDTH: result a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout, output, 1: carry-out of the WIDTH-bit addition.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE (busy=0); an accepted start at edge k loads a and b into shift registers, loads cin into the carry flop, clears the bit counter and enters SHIFT.
REQ-014 SHALL, in SHIFT, at each edge k+1+i (i=0..WIDTH-1), add LSB(a_sh), LSB(b_sh) and the carry flop through one full-adder cell.
- Each such edge shifts a_sh and b_sh right by one.
- Each such edge shifts the full-adder sum bit into the MSB of the sum register (shift right).
- Each such edge loads the full-adder carry into the carry flop.
REQ-015 SHALL leave SHIFT for DONE at edge k+WIDTH, once the counter reaches WIDTH-1; done=1 and busy=0 for exactly the following cycle.
REQ-016 SHALL have a latency of WIDTH+1 cycles from start sampled to done high; throughput is one addition per WIDTH+1 cycles.
REQ-017 SHALL present the final carry flop on cout and the completed register on sum from the DONE cycle onward, holding both until the next accepted start.
REQ-018 SHALL drive busy=1 in SHIFT only; busy is a registered state decode with no combinational path from start.
REQ-019 SHALL ignore start, a, b and cin while busy=1, with no effect on the operation in progress.
REQ-020 SHALL treat start high in DONE as accepted, producing back-to-back operations with no IDLE cycle; without start, DONE returns to IDLE.
REQ-021 SHALL size the counter as ceil(log2(WIDTH)) bits; wrap-around is never reached, because the exit compare is at WIDTH-1.

Reset
REQ-022 SHALL, with rst high at an edge, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0 and shift registers=0.
REQ-023 SHALL let rst win over start at the same edge; an operation interrupted by reset produces no done pulse and leaves outputs zero.

Structure
REQ-024 SHALL place the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-025 SHALL instantiate the existing gate-level fulladder module exactly once as its single bit-slice sub-module; no other arithmetic operators appear in the datapath.
REQ-026 SHALL keep control (FSM, counter) and datapath (shift registers, carry flop) in separate always blocks inside serial_adder.

Verification
REQ-027 Bench SHALL check, with WIDTH=8: start with a=8'h0F, b=8'h01, cin=0 -> done 9 cycles later, sum=8'h10, cout=0.
REQ-028 Bench SHALL check: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-029 Bench SHALL check: start pulsed with a=8'h55, b=8'hAA; during busy, start re-pulsed with a=8'h01, b=8'h01 -> single done, sum=8'hFF, cout=0.
REQ-030 Bench SHALL check: rst asserted 4 cycles into an operation -> next cycle busy=0, sum=0, cout=0, and no done pulse.
REQ-031 Bench SHALL check: start held high in the DONE cycle with a=8'h80, b=8'h80, cin=0 -> busy next cycle, second done 9 cycles later with sum=8'h00, cout=1.
REQ-032 Bench SHALL run an exhaustive sweep at WIDTH=4 over all a, b and cin values -> {cout,sum} equals a+b+cin on every done.
